elut_config_writer: RTL and testbench
=====================================

# elut_config_writer

Configuration writer for one LUTRAM-based eLUT. It accepts a 2**K-bit LUT mask as a stream of DATA_W-bit words over a valid/ready handshake. It writes the mask into the eLUT's write port one bit per cycle, then reads each written word back through the write-address output port and flags mismatches. It sits between the overlay configuration controller and each eLUT's write-side ports: a, d, we, clk, plus the unregistered output dpo.

## Interface
Parameters:
- K, 6: LUT address width. The mask holds 2**K bits.
- DATA_W, 16: config word width. Must be a power of two, with DATA_W ≤ 2**K.

Ports:
- clk, in, 1: single clock, shared with the eLUT write clock.
- rst_n, in, 1: asynchronous, active-low reset.
- start, in, 1: begins a load session. Honoured only in IDLE.
- abort, in, 1: terminates the session. Honoured in LOAD, WRITE and VERIFY.
- cfg_data, in, DATA_W: mask word.
- cfg_valid, in, 1: cfg_data is valid.
- cfg_ready, out, 1: writer accepts a word this cycle.
- lut_a, out, K: eLUT write/read address.
- lut_d, out, 1: eLUT write data.
- lut_we, out, 1: eLUT write enable.
- lut_dpo, in, 1: eLUT unregistered output at address lut_a.
- busy, out, 1: session in progress.
- done, out, 1: one-cycle pulse when a session completes.
- err, out, 1: sticky readback-mismatch flag.

## Operation
- FSM states: IDLE, LOAD, WRITE, VERIFY, DONE.
- Registers:
  - word: DATA_W-bit captured word.
  - cnt: log2(DATA_W)-bit bit index.
  - base: K-bit word base address.
- IDLE:
  - All outputs are low; lut_a = 0.
  - start=1 → LOAD, with base=0 and err cleared.
- LOAD:
  - cfg_ready=1.
  - cfg_valid & cfg_ready → word=cfg_data, cnt=0, → WRITE.
  - Otherwise hold in LOAD.
- WRITE:
  - Drive lut_we=1, lut_a=base+cnt, lut_d=word[cnt]. Bits are written LSB first.
  - Word w, bit i maps to address w*DATA_W+i.
  - When cnt=DATA_W-1: cnt=0, → VERIFY. Otherwise cnt++.
- VERIFY:
  - Drive lut_we=0, lut_a=base+cnt.
  - At the clock edge, lut_dpo≠word[cnt] sets err.
  - After the last bit:
    - if base+DATA_W = 2**K → DONE;
    - else base += DATA_W, → LOAD.
- DONE: done=1 for one cycle, → IDLE.
- Flags:
  - busy=1 in every state except IDLE.
  - err is cleared only by reset or by an accepted start, never by abort.
- Abort:
  - abort=1 in LOAD, WRITE or VERIFY → IDLE on the next edge, with no done pulse.
  - If the abort edge coincides with a LOAD handshake, the word is discarded.
  - Abort has priority over every other transition.
  - Writes already performed stay in the eLUT.
- Inputs outside their honouring state are ignored:
  - start while busy;
  - cfg_valid outside LOAD;
  - abort in IDLE or DONE.
- All outputs decode from registered state, cnt, base and word. There is no combinational path from any input to any output.
- base+cnt is computed in K bits. It never wraps, because 2**K is a multiple of DATA_W.

## Timing
- Reset: state=IDLE. cfg_ready, lut_we, lut_d, busy, done and err are 0; lut_a=0.
- Start: start sampled at edge n → cfg_ready=1 in cycle n+1.
- Per word: 1 handshake cycle (minimum), then DATA_W write cycles, then DATA_W verify cycles.
- With cfg_valid held high, a full session takes (2**K/DATA_W)·(1+2·DATA_W)+1 cycles from start to done inclusive. For K=6, DATA_W=16 that is 133 cycles.
- Verify latency: the eLUT write is committed on the edge ending a WRITE cycle. The first VERIFY read therefore occurs at least DATA_W cycles after that address was written.
- cfg_valid low in LOAD stalls with no timeout. lut_we stays 0 while stalled.

## Test plan
- Reset mid-WRITE: assert rst_n=0 asynchronously during a WRITE cycle → lut_we=0, busy=0, err=0 immediately, without waiting for clk. start after release → a fresh session with base=0.
- Full load, K=6, DATA_W=16, valid always high:
  - Stimulus: words 0xA5A5, 0x0001, 0x8000, 0xFFFF.
  - Model: eLUT behavioural RAM.
  - Required: RAM equals 0xFFFF_8000_0001_A5A5; done pulses at cycle 133; err=0; exactly 64 lut_we cycles.
- Stalled handshake:
  - Stimulus: cfg_valid low for 10 cycles before word 2.
  - Required: cfg_ready held high, lut_we=0 throughout the stall, final RAM contents unchanged from the full-load case, done at cycle 143.
- Readback fault:
  - Stimulus: model forces RAM address 37 stuck at 0; write word 2 = 0x0020.
  - Required: err=1 from the verify of bit 5 onward, still 1 after done; next start clears it.
- Abort mid-VERIFY of word 1:
  - Required: IDLE next cycle, busy=0, no done pulse.
  - Required: start asserted in the same cycle as abort is ignored; a later start restarts at address 0.

Source files
------------

// File: rtl/elut_config_writer.sv
// elut_config_writer: streams a 2**K-bit LUT mask into one LUTRAM-based eLUT,
// one bit per cycle (LSB first). After each word it reads every bit back
// through the write-address port (dpo) and raises a sticky error on mismatch.
// All outputs are decoded from registered state only, so no input reaches an
// output combinationally.
module elut_config_writer #(
    parameter int K      = 6,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic [K-1:0]      lut_a,
    output logic              lut_d,
    output logic              lut_we,
    input  logic              lut_dpo,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int               CNT_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    // Base of the final word; reaching it means the mask is complete.
    localparam logic [K-1:0]     LAST_BASE = K'((2 ** K) - DATA_W);
    localparam logic [K-1:0]     BASE_STEP = K'(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_VERIFY = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_word;
    logic [DATA_W-1:0]   w_word_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [K-1:0]        r_base;
    logic [K-1:0]        w_base_nxt;
    logic                r_err;
    logic                w_err_nxt;

    logic [K-1:0]        w_addr;
    logic                w_bit;
    logic                w_last_bit;
    logic                w_last_word;

    // base+cnt never wraps because 2**K is a multiple of DATA_W.
    assign w_addr      = r_base + K'(r_cnt);
    assign w_bit       = r_word[r_cnt];
    assign w_last_bit  = (r_cnt == LAST_CNT);
    assign w_last_word = (r_base == LAST_BASE);

    // State and datapath registers; reset returns to an idle, error-free writer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_word  <= {DATA_W{1'b0}};
            r_cnt   <= {CNT_W{1'b0}};
            r_base  <= {K{1'b0}};
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_word  <= w_word_nxt;
            r_cnt   <= w_cnt_nxt;
            r_base  <= w_base_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Next-state logic; abort overrides every other transition in LOAD/WRITE/VERIFY.
    always_comb begin
        w_state_nxt = r_state;
        w_word_nxt  = r_word;
        w_cnt_nxt   = r_cnt;
        w_base_nxt  = r_base;
        w_err_nxt   = r_err;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_LOAD;
                    w_base_nxt  = {K{1'b0}};
                    w_err_nxt   = 1'b0;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (cfg_valid) begin
                    w_word_nxt  = cfg_data;
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    w_state_nxt = ST_WRITE;
                end else begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_WRITE: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_last_bit) begin
                    w_cnt_nxt   = {CNT_W{1'b0}};
                    w_state_nxt = ST_VERIFY;
                end else begin
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                end
            end
            ST_VERIFY: begin
                if (abort) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    if (lut_dpo != w_bit) begin
                        w_err_nxt = 1'b1;
                    end else begin
                        w_err_nxt = r_err;
                    end
                    if (w_last_bit) begin
                        w_cnt_nxt = {CNT_W{1'b0}};
                        if (w_last_word) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_base_nxt  = r_base + BASE_STEP;
                            w_state_nxt = ST_LOAD;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode from registered state, counter, base and word only.
    always_comb begin
        cfg_ready = 1'b0;
        lut_we    = 1'b0;
        lut_d     = 1'b0;
        lut_a     = {K{1'b0}};
        busy      = 1'b1;
        done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
            end
            ST_LOAD: begin
                cfg_ready = 1'b1;
            end
            ST_WRITE: begin
                lut_we = 1'b1;
                lut_d  = w_bit;
                lut_a  = w_addr;
            end
            ST_VERIFY: begin
                lut_a = w_addr;
            end
            ST_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign err = r_err;

endmodule

// File: tb/tb_elut_config_writer.sv
// Scoreboard bench for elut_config_writer (K=6, DATA_W=16). Stimulus tasks
// push expected eLUT writes, done events and error-rise cycles into queues; a
// negedge monitor pops and compares whenever the DUT presents them.
module tb_elut_config_writer;

    localparam int K  = 6;
    localparam int DW = 16;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [DW-1:0] cfg_data = 16'h0000;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [K-1:0]  lut_a;
    logic          lut_d;
    logic          lut_we;
    logic          lut_dpo;
    logic          busy;
    logic          done;
    logic          err;

    elut_config_writer #(.K(K), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .lut_a(lut_a), .lut_d(lut_d), .lut_we(lut_we), .lut_dpo(lut_dpo),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural eLUT: synchronous write, asynchronous read, optional stuck-at-0 cell.
    logic         ram [64];
    bit           stuck_en = 1'b0;
    logic [K-1:0] stuck_addr = 6'd0;
    assign lut_dpo = (stuck_en && lut_a == stuck_addr) ? 1'b0 : ram[lut_a];
    always @(posedge clk) if (lut_we) ram[lut_a] <= lut_d;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [K-1:0] a; logic d; } wr_t;
    typedef struct { int c; logic e; logic [63:0] m; int we0; } done_t;
    wr_t   wr_q[$];
    done_t done_q[$];
    int    rise_q[$];

    int vectors = 0, errors = 0, we_total = 0, done_seen = 0;
    logic prev_err = 1'b0;
    wr_t   mon_w;
    done_t mon_d;
    int    mon_r;

    logic [DW-1:0] words [NW];
    int            stalls[NW];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag_fail(input string name);
        vectors++;
        errors++;
        $display("FAIL %s: event not expected by the model (t=%0t)", name, $time);
    endtask

    function automatic logic [63:0] ram_vec();
        logic [63:0] v;
        for (int i = 0; i < 64; i++) v[i] = ram[i];
        return v;
    endfunction

    // Monitor: compare every write, done pulse and error rise against the scoreboard.
    always @(negedge clk) begin
        if (lut_we) begin
            we_total++;
            if (wr_q.size() == 0) flag_fail("unexpected_we");
            else begin
                mon_w = wr_q.pop_front();
                check("we_addr", 64'(lut_a), 64'(mon_w.a));
                check("we_data", 64'(lut_d), 64'(mon_w.d));
            end
        end
        if (done) begin
            done_seen++;
            if (done_q.size() == 0) flag_fail("unexpected_done");
            else begin
                mon_d = done_q.pop_front();
                check("done_cycle", 64'(cyc), 64'(mon_d.c));
                check("done_err", 64'(err), 64'(mon_d.e));
                check("ram_image", ram_vec(), mon_d.m);
                check("we_count", 64'(we_total - mon_d.we0), 64'd64);
            end
        end
        if (err && !prev_err) begin
            if (rise_q.size() == 0) flag_fail("unexpected_err");
            else begin
                mon_r = rise_q.pop_front();
                check("err_rise_cycle", 64'(cyc), 64'(mon_r));
            end
        end
        prev_err = err;
    end

    // Drive start for one cycle; when a full session is expected, predict its outcome.
    task automatic issue_start(input bit expect_done);
        logic [63:0] m;
        int st, w, s;
        @(posedge clk); #1;
        start = 1'b1;
        if (expect_done) begin
            st = 0;
            for (int i = 0; i < NW; i++) begin
                m[i*DW +: DW] = words[i];
                st += stalls[i];
            end
            done_q.push_back('{cyc + 133 + st, stuck_en && m[stuck_addr], m, we_total});
            if (stuck_en && m[stuck_addr]) begin
                w = int'(stuck_addr) / DW;
                s = 0;
                for (int j = 0; j <= w; j++) s += stalls[j];
                rise_q.push_back(cyc + 19 + 33 * w + int'(stuck_addr) % DW + s);
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Offer one word after waiting for LOAD and stalling 'stall' extra LOAD cycles.
    task automatic feed_word(input logic [DW-1:0] w, input int stall, input int idx);
        int n;
        n = 0;
        @(negedge clk);
        while (!cfg_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cfg_ready) begin
            flag_fail("ready_timeout");
            return;
        end
        for (int s = 0; s < stall; s++) begin
            check("stall_ready", 64'(cfg_ready), 64'd1);
            check("stall_we", 64'(lut_we), 64'd0);
            @(negedge clk);
        end
        cfg_data  = w;
        cfg_valid = 1'b1;
        for (int i = 0; i < DW; i++) wr_q.push_back('{K'(idx * DW + i), w[i]});
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic wait_done();
        int d0, n;
        d0 = done_seen;
        n = 0;
        while (done_seen == d0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (done_seen == d0) flag_fail("done_timeout");
    endtask

    task automatic run_session();
        issue_start(1'b1);
        check("err_cleared_on_start", 64'(err), 64'd0);
        check("busy_after_start", 64'(busy), 64'd1);
        for (int w = 0; w < NW; w++) feed_word(words[w], stalls[w], w);
        wait_done();
        @(negedge clk);
        check("idle_after_done", 64'(busy), 64'd0);
    endtask

    task automatic rand_words();
        for (int w = 0; w < NW; w++) begin
            words[w]  = 16'($urandom);
            stalls[w] = 0;
        end
    endtask

    initial begin
        // Reset values while rst_n is held low.
        #12;
        check("rst_cfg_ready", 64'(cfg_ready), 64'd0);
        check("rst_lut_we", 64'(lut_we), 64'd0);
        check("rst_lut_d", 64'(lut_d), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_lut_a", 64'(lut_a), 64'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;

        // Full load with known words.
        words[0] = 16'hA5A5; words[1] = 16'h0001; words[2] = 16'h8000; words[3] = 16'hFFFF;
        for (int w = 0; w < NW; w++) stalls[w] = 0;
        run_session();

        // Same words, 10-cycle stall before the third word.
        stalls[2] = 10;
        run_session();

        // Readback fault: address 37 stuck at 0, written as 1.
        rand_words();
        words[2]   = 16'h0020;
        stuck_en   = 1'b1;
        stuck_addr = 6'd37;
        run_session();
        check("err_sticky_after_done", 64'(err), 64'd1);
        stuck_en = 1'b0;
        rand_words();
        run_session();

        // Abort during VERIFY of word 1, with a simultaneous start that must be ignored.
        rand_words();
        issue_start(1'b0);
        feed_word(words[0], 0, 0);
        feed_word(words[1], 0, 1);
        repeat (18) @(posedge clk);
        #1;
        check("busy_before_abort", 64'(busy), 64'd1);
        abort = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        start = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_ready", 64'(cfg_ready), 64'd0);
        check("abort_lut_a", 64'(lut_a), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        repeat (5) @(posedge clk);
        #1;
        check("abort_start_ignored", 64'(busy), 64'd0);
        check("abort_writes_drained", 64'(wr_q.size()), 64'd0);
        rand_words();
        run_session();

        // Asynchronous reset in the middle of WRITE of word 1, after word 0 failed verify.
        rand_words();
        stuck_en   = 1'b1;
        stuck_addr = K'($urandom_range(0, 15));
        words[0]   = words[0] | (16'(1) << stuck_addr[3:0]);
        issue_start(1'b1);
        feed_word(words[0], 0, 0);
        feed_word(words[1], 0, 1);
        repeat (3) @(posedge clk);
        #3;
        check("err_before_reset", 64'(err), 64'd1);
        check("we_before_reset", 64'(lut_we), 64'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_we", 64'(lut_we), 64'd0);
        check("async_rst_busy", 64'(busy), 64'd0);
        check("async_rst_err", 64'(err), 64'd0);
        wr_q.delete();
        done_q.delete();
        rise_q.delete();
        stuck_en = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        rand_words();
        run_session();

        // Randomized sessions with random stalls and an optional stuck cell.
        for (int r = 0; r < 4; r++) begin
            rand_words();
            for (int w = 0; w < NW; w++) stalls[w] = $urandom_range(0, 3);
            stuck_en   = ($urandom_range(0, 1) == 1);
            stuck_addr = K'($urandom_range(0, 63));
            run_session();
        end
        stuck_en = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("wr_q_empty", 64'(wr_q.size()), 64'd0);
        check("done_q_empty", 64'(done_q.size()), 64'd0);
        check("rise_q_empty", 64'(rise_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
